// File: rtl/scramble_frame_ctrl_if.sv
// Control bundle between the scrambler datapath top level and its frame
// sequencer.
//   master : the datapath side. It drives the sample strobe, seed and
//            reorder counts, and receives the enables, reset and key.
//   slave  : the sequencer side, scramble_frame_ctrl.
// Signals:
//   sample_valid, scramble_on, seed_load, seed[23:0],
//   rev_do_count, out_do_count                           master -> slave
//   fft_di_en, shift_key[23:0], ifft_reset, ifft_di_en,
//   out_valid, frame_start, frame_count[15:0]            slave -> master
interface scramble_frame_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             sample_valid;
  logic             scramble_on;
  logic             seed_load;
  logic [23:0]      seed;
  logic [CNT_W-1:0] rev_do_count;
  logic [CNT_W-1:0] out_do_count;
  logic             fft_di_en;
  logic [23:0]      shift_key;
  logic             ifft_reset;
  logic             ifft_di_en;
  logic             out_valid;
  logic             frame_start;
  logic [15:0]      frame_count;

  modport master (
    output sample_valid, scramble_on, seed_load, seed, rev_do_count, out_do_count,
    input  fft_di_en, shift_key, ifft_reset, ifft_di_en, out_valid, frame_start, frame_count
  );

  modport slave (
    input  sample_valid, scramble_on, seed_load, seed, rev_do_count, out_do_count,
    output fft_di_en, shift_key, ifft_reset, ifft_di_en, out_valid, frame_start, frame_count
  );
endinterface

// File: rtl/scramble_frame_ctrl.sv
// Frame sequencer for the 64-point audio scrambling pipeline.
// It does four jobs:
//   - counts input samples into frames and gates the forward FFT input enable;
//   - produces a fresh 24-bit shift key per frame from a seeded LFSR;
//   - sequences the IFFT reset and input enable from the reorder-stage count;
//   - flags when the output stream carries valid samples.
// Ports:
//   clock : single master clock, equal to the audio sample clock.
//   reset : synchronous, active-low.
//   bus   : scramble_frame_ctrl_if.slave. It carries the sample strobe,
//           scramble enable, seed load/value and the reorder counts in, and
//           fft_di_en, shift_key, ifft_reset, ifft_di_en, out_valid,
//           frame_start and frame_count out.
module scramble_frame_ctrl #(
  parameter int FRAME_LEN   = 64,
  parameter int CNT_W       = 8,
  parameter int IFFT_RST_AT = 6,
  parameter int IFFT_EN_AT  = 8,
  parameter int KEY_UPD_AT  = 0,
  parameter int OUT_EN_AT   = 8
) (
  input logic                  clock,
  input logic                  reset,
  scramble_frame_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  typedef enum logic {
    IN_IDLE,
    IN_RUN
  } in_state_t;

  typedef enum logic [1:0] {
    IF_WAIT,
    IF_RST,
    IF_ARM,
    IF_STREAM
  } ifft_state_t;

  in_state_t        in_state_reg;
  ifft_state_t      ifft_state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [15:0]      frame_count_reg;
  logic             frame_start_reg;
  logic             fft_di_en_reg;
  logic             rst_cnt_reg;
  logic             ifft_reset_reg;
  logic             ifft_di_en_reg;
  logic             out_valid_reg;
  logic [23:0]      lfsr_reg;
  logic [23:0]      shift_key_reg;

  logic [23:0]      lfsr_next;
  logic             key_upd;

  // Fibonacci step: taps 24,23,22,17, which are bits 23,22,21,16.
  assign lfsr_next = {lfsr_reg[22:0],
                      lfsr_reg[23] ^ lfsr_reg[22] ^ lfsr_reg[21] ^ lfsr_reg[16]};

  // The key only advances once the IFFT side is out of WAIT. This keeps the
  // count pattern seen before the pipeline has filled from consuming LFSR
  // steps.
  assign key_upd = (bus.rev_do_count == CNT_W'(KEY_UPD_AT)) && (ifft_state_reg != IF_WAIT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      in_state_reg    <= IN_IDLE;
      ifft_state_reg  <= IF_WAIT;
      idx_reg         <= '0;
      frame_count_reg <= '0;
      frame_start_reg <= 1'b0;
      fft_di_en_reg   <= 1'b0;
      rst_cnt_reg     <= 1'b0;
      ifft_reset_reg  <= 1'b1;
      ifft_di_en_reg  <= 1'b0;
      out_valid_reg   <= 1'b0;
      lfsr_reg        <= 24'h000001;
      shift_key_reg   <= 24'h000000;
    end else begin
      // Input FSM. In IDLE the index is still 0, so the sample that starts
      // the run is counted as index 0 by the counting logic below.
      case (in_state_reg)
        IN_IDLE: begin
          fft_di_en_reg <= bus.sample_valid;
          if (bus.sample_valid) begin
            in_state_reg <= IN_RUN;
          end
        end
        default: begin
          fft_di_en_reg <= bus.sample_valid;
        end
      endcase

      // Sample index. A gap in sample_valid freezes the index, so frames are
      // never dropped or padded.
      frame_start_reg <= bus.sample_valid && (idx_reg == '0);
      if (bus.sample_valid) begin
        idx_reg <= idx_reg + 1'b1;
        if (idx_reg == IDX_W'(FRAME_LEN - 1)) begin
          frame_count_reg <= frame_count_reg + 16'd1;
        end
      end

      // IFFT sequencing. ifft_reset stays high through WAIT and the two RST
      // cycles, and drops as the FSM enters ARM.
      case (ifft_state_reg)
        IF_WAIT: begin
          if ((in_state_reg == IN_RUN) && (bus.rev_do_count == CNT_W'(IFFT_RST_AT))) begin
            ifft_state_reg <= IF_RST;
            rst_cnt_reg    <= 1'b0;
          end
        end
        IF_RST: begin
          if (rst_cnt_reg) begin
            ifft_state_reg <= IF_ARM;
            ifft_reset_reg <= 1'b0;
          end else begin
            rst_cnt_reg <= 1'b1;
          end
        end
        IF_ARM: begin
          if (bus.rev_do_count == CNT_W'(IFFT_EN_AT)) begin
            ifft_state_reg <= IF_STREAM;
            ifft_di_en_reg <= 1'b1;
          end
        end
        default: begin
          if (bus.out_do_count == CNT_W'(OUT_EN_AT)) begin
            out_valid_reg <= 1'b1;
          end
        end
      endcase

      // A seed load overrides a key update in the same cycle. The key then
      // keeps its old value. A zero seed would lock the LFSR, so it is
      // forced to 1.
      if (bus.seed_load) begin
        lfsr_reg <= (bus.seed == 24'h000000) ? 24'h000001 : bus.seed;
      end else if (key_upd) begin
        lfsr_reg      <= lfsr_next;
        shift_key_reg <= bus.scramble_on ? lfsr_next : 24'h000000;
      end
    end
  end

  assign bus.fft_di_en   = fft_di_en_reg;
  assign bus.shift_key   = shift_key_reg;
  assign bus.ifft_reset  = ifft_reset_reg;
  assign bus.ifft_di_en  = ifft_di_en_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.frame_count = frame_count_reg;

endmodule

// File: tb/tb_scramble_frame_ctrl.sv
module tb_scramble_frame_ctrl;

  logic clock;
  logic reset;

  scramble_frame_ctrl_if #(.CNT_W(8)) bus ();

  scramble_frame_ctrl #(
    .FRAME_LEN  (64),
    .CNT_W      (8),
    .IFFT_RST_AT(6),
    .IFFT_EN_AT (8),
    .KEY_UPD_AT (0),
    .OUT_EN_AT  (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        sv;
    logic        scr;
    logic        sl;
    logic [23:0] seed;
    logic [7:0]  rev;
    logic [7:0]  outc;
    logic        e_fft;
    logic        e_rst;
    logic        e_di;
    logic        e_ov;
    logic        e_fs;
    logic [23:0] e_key;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [23:0] lfsr_step(input logic [23:0] v);
    lfsr_step = {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
  endfunction

  task automatic do_reset(input int cycles, input logic sv);
    reset = 1'b0;
    bus.sample_valid = sv;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " fft_di_en"},   32'(bus.fft_di_en),   32'd0);
    chk({tag, " ifft_reset"},  32'(bus.ifft_reset),  32'd1);
    chk({tag, " ifft_di_en"},  32'(bus.ifft_di_en),  32'd0);
    chk({tag, " out_valid"},   32'(bus.out_valid),   32'd0);
    chk({tag, " frame_start"}, 32'(bus.frame_start), 32'd0);
    chk({tag, " frame_count"}, 32'(bus.frame_count), 32'd0);
    chk({tag, " shift_key"},   32'(bus.shift_key),   32'd0);
  endtask

  initial begin
    int first_fs;
    int second_fs;
    logic [23:0] model;

    reset = 1'b0;
    bus.sample_valid = 1'b0;
    bus.scramble_on  = 1'b0;
    bus.seed_load    = 1'b0;
    bus.seed         = 24'h0;
    bus.rev_do_count = 8'd0;
    bus.out_do_count = 8'd0;

    // Rows: sv scr sl seed rev out | fft rst di ov fs key
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 24'hABCDEF, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd5, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd6, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd7, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd8, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd8, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h579BDF};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd1, 8'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h579BDF};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'hAF37BE};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'hBCDEFB};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 24'h000000, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'hBCDEFB};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000002};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'd3, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000002};

    // Reset held with samples present; then the first sample after release.
    do_reset(3, 1'b1);
    reset = 1'b0;
    chk_reset_values("reset");
    reset = 1'b1;
    bus.sample_valid = 1'b1;
    tick();
    chk("first frame_start", 32'(bus.frame_start), 32'd1);
    chk("first fft_di_en", 32'(bus.fft_di_en), 32'd1);
    bus.sample_valid = 1'b0;
    tick();
    chk("idle frame_start", 32'(bus.frame_start), 32'd0);
    chk("idle fft_di_en", 32'(bus.fft_di_en), 32'd0);
    $display("reset sequence done");

    // Continuous stream of 130 samples.
    do_reset(1, 1'b0);
    for (int k = 0; k < 130; k++) begin
      bus.sample_valid = 1'b1;
      tick();
      chk($sformatf("stream fs k=%0d", k), 32'(bus.frame_start), 32'((k % 64) == 0));
      if (k == 63)  chk("frame_count after 63", 32'(bus.frame_count), 32'd1);
      if (k == 127) chk("frame_count after 127", 32'(bus.frame_count), 32'd2);
    end
    bus.sample_valid = 1'b0;
    $display("stream of 130 samples done, frame_count=%0d", bus.frame_count);

    // Five-cycle gap at index 30.
    do_reset(1, 1'b0);
    first_fs = -1;
    second_fs = -1;
    for (int c = 0; c < 100; c++) begin
      bus.sample_valid = !(c >= 30 && c < 35);
      tick();
      if (bus.frame_start) begin
        if (first_fs < 0) first_fs = c;
        else if (second_fs < 0) second_fs = c;
      end
    end
    bus.sample_valid = 1'b0;
    chk("gap first frame_start", 32'(first_fs), 32'd0);
    chk("gap frame_start spacing", 32'(second_fs - first_fs), 32'd69);
    chk("gap frame_count", 32'(bus.frame_count), 32'd1);
    $display("gap test: frame_start at %0d and %0d", first_fs, second_fs);

    // Table: seeding, IFFT sequencing, key updates, zero seed.
    do_reset(1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      bus.sample_valid = vecs[i].sv;
      bus.scramble_on  = vecs[i].scr;
      bus.seed_load    = vecs[i].sl;
      bus.seed         = vecs[i].seed;
      bus.rev_do_count = vecs[i].rev;
      bus.out_do_count = vecs[i].outc;
      tick();
      chk($sformatf("vec%0d fft_di_en", i),   32'(bus.fft_di_en),   32'(vecs[i].e_fft));
      chk($sformatf("vec%0d ifft_reset", i),  32'(bus.ifft_reset),  32'(vecs[i].e_rst));
      chk($sformatf("vec%0d ifft_di_en", i),  32'(bus.ifft_di_en),  32'(vecs[i].e_di));
      chk($sformatf("vec%0d out_valid", i),   32'(bus.out_valid),   32'(vecs[i].e_ov));
      chk($sformatf("vec%0d frame_start", i), 32'(bus.frame_start), 32'(vecs[i].e_fs));
      chk($sformatf("vec%0d shift_key", i),   32'(bus.shift_key),   32'(vecs[i].e_key));
      $display("vec%0d rev=%0d out=%0d key=%06h rst=%0b di=%0b ov=%0b",
               i, vecs[i].rev, vecs[i].outc, bus.shift_key, bus.ifft_reset,
               bus.ifft_di_en, bus.out_valid);
    end
    bus.seed_load = 1'b0;

    // Sweep the reorder count 0..71 twice: one LFSR step per frame.
    model = 24'h000002;
    bus.scramble_on = 1'b1;
    for (int c = 0; c < 144; c++) begin
      bus.rev_do_count = 8'(c % 72);
      tick();
      if ((c % 72) == 0) model = lfsr_step(model);
      chk($sformatf("sweep key c=%0d", c), 32'(bus.shift_key), 32'(model));
    end
    $display("sweep done, key=%06h", bus.shift_key);

    // Reset in the middle of streaming.
    bus.rev_do_count = 8'd0;
    bus.out_do_count = 8'd8;
    reset = 1'b0;
    tick();
    chk_reset_values("midreset");
    reset = 1'b1;
    bus.sample_valid = 1'b1;
    tick();
    chk("midreset restart frame_start", 32'(bus.frame_start), 32'd1);
    chk("midreset shift_key held", 32'(bus.shift_key), 32'd0);
    $display("mid-operation reset done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
